// File: rtl/tx_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM state encoding,
// default parameter values and the baud timer width.
package tx_pkg;

    localparam int unsigned DEF_CLK_FREQUENCY = 100_000_000;
    localparam int unsigned DEF_BAUD_RATE     = 19_200;
    localparam bit          DEF_PARITY_BIT    = 1'b1;
    localparam int unsigned TIMER_W           = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SRT  = 3'd1,
        BITS = 3'd2,
        PAR  = 3'd3,
        STP  = 3'd4,
        ACK  = 3'd5
    } uart_state_e;

endpackage

// File: rtl/tx_baud_timer.sv
// Free-running bit-period timer: counts 0..TIMER_MAX-1 and pulses done on the
// last count, so every period is exactly TIMER_MAX cycles. clr restarts it.
module baud_timer
    import tx_pkg::*;
#(
    parameter int unsigned TIMER_MAX = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic done
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMER_MAX - 1);
    localparam logic [TIMER_W-1:0] ONE  = TIMER_W'(1);

    logic [TIMER_W-1:0] count_q, count_d;

    assign done = (count_q == LAST);

    always_comb begin
        count_d = count_q + ONE;
        if (clr || done) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tx.sv
// UART transmitter: 8 data bits LSB first, one parity bit, one stop bit.
// One frame per send assertion; ACK holds until send is released.
module tx
    import tx_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = DEF_CLK_FREQUENCY,
    parameter int unsigned BAUD_RATE     = DEF_BAUD_RATE,
    parameter bit          PARITY_BIT    = DEF_PARITY_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        send,
    output logic        tx_out,
    output logic        busy,
    output uart_state_e dbg_state_o
);

    localparam int unsigned BAUD_TIMER_MAX = CLK_FREQUENCY / BAUD_RATE;

    if (BAUD_TIMER_MAX < 2) begin : g_bad_baud
        $error("tx: BAUD_TIMER_MAX = CLK_FREQUENCY/BAUD_RATE must be at least 2");
    end

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        timer_clr;
    logic        baud_done;

    // Holding the timer clear while waiting makes the start bit begin a full period.
    assign timer_clr   = (state_q == IDLE) || (state_q == ACK);
    assign tx_out      = tx_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

    baud_timer #(
        .TIMER_MAX(BAUD_TIMER_MAX)
    ) u_baud_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .done(baud_done)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (send) begin
                    state_d = SRT;
                    shift_d = din;
                    par_d   = PARITY_BIT;
                    cnt_d   = 3'd0;
                    tx_d    = 1'b0;
                end
            end
            SRT: begin
                if (baud_done) begin
                    state_d = BITS;
                    cnt_d   = 3'd0;
                    tx_d    = shift_q[0];
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            BITS: begin
                if (baud_done) begin
                    if (cnt_q == 3'd7) begin
                        state_d = PAR;
                        tx_d    = par_q;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        tx_d    = shift_q[0];
                        par_d   = par_q ^ shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PAR: begin
                if (baud_done) begin
                    state_d = STP;
                    tx_d    = 1'b1;
                end
            end
            STP: begin
                if (baud_done) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                tx_d = 1'b1;
                if (!send) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= 8'h00;
            cnt_q   <= 3'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_tx.sv
// Bench for tx: odd- and even-parity instances share all inputs, 10 clocks per bit.
module tb_tx;
    import tx_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        send;
    logic [7:0]  din;
    logic        tx_odd, tx_even, busy_odd, busy_even;
    uart_state_e st_odd, st_even;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] din;
        logic       par_odd;
        logic       par_even;
        int         drop_c;
        int         chg_c;
        logic [7:0] chg_val;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    tx #(.CLK_FREQUENCY(1000), .BAUD_RATE(100), .PARITY_BIT(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .din(din), .send(send),
        .tx_out(tx_odd), .busy(busy_odd), .dbg_state_o(st_odd)
    );

    tx #(.CLK_FREQUENCY(1000), .BAUD_RATE(100), .PARITY_BIT(1'b0)) dut_even (
        .clk(clk), .rst(rst), .din(din), .send(send),
        .tx_out(tx_even), .busy(busy_even), .dbg_state_o(st_even)
    );

    task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, act, exp);
        end
    endtask

    // Called at a negedge with both DUTs idle; c counts negedges after acceptance.
    task automatic run_frame(input vec_t v);
        logic [10:0] f_odd, f_even;
        logic        exp_odd, exp_even;
        int          busy_low_c, last_c;
        f_odd      = {1'b1, v.par_odd, v.din, 1'b0};
        f_even     = {1'b1, v.par_even, v.din, 1'b0};
        busy_low_c = (v.drop_c + 1 > 111) ? v.drop_c + 1 : 111;
        last_c     = busy_low_c + 2;
        din  = v.din;
        send = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= last_c; c++) begin
            exp_odd  = (c < 110) ? f_odd[c/10]  : 1'b1;
            exp_even = (c < 110) ? f_even[c/10] : 1'b1;
            chk("tx_odd", c, {7'b0, tx_odd}, {7'b0, exp_odd});
            chk("tx_even", c, {7'b0, tx_even}, {7'b0, exp_even});
            chk("busy_odd", c, {7'b0, busy_odd}, {7'b0, c < busy_low_c});
            chk("busy_even", c, {7'b0, busy_even}, {7'b0, c < busy_low_c});
            if (c == v.drop_c) send = 1'b0;
            if (c == v.chg_c) din = v.chg_val;
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{8'h41, 1'b1, 1'b0, 0, -1, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 0, -1, 8'h00};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 0, -1, 8'h00};
        vecs[3] = '{8'h01, 1'b0, 1'b1, 0, -1, 8'h00};
        vecs[4] = '{8'hA5, 1'b1, 1'b0, 0, -1, 8'h00};
        vecs[5] = '{8'h07, 1'b0, 1'b1, 0, -1, 8'h00};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 5, -1, 8'h00};

        rst  = 1'b0;
        send = 1'b1;
        din  = 8'h55;
        repeat (3) @(negedge clk);
        chk("rst_tx_odd", 0, {7'b0, tx_odd}, 8'h01);
        chk("rst_tx_even", 0, {7'b0, tx_even}, 8'h01);
        chk("rst_busy_odd", 0, {7'b0, busy_odd}, 8'h00);
        chk("rst_busy_even", 0, {7'b0, busy_even}, 8'h00);
        chk("rst_state", 0, {5'b0, st_odd}, {5'b0, IDLE});
        send = 1'b0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i]);
            repeat (2) @(negedge clk);
        end

        // send held high for 300 cycles: one frame, busy until send drops
        run_frame('{8'h41, 1'b1, 1'b0, 299, -1, 8'h00});
        repeat (2) @(negedge clk);

        // din changes mid-frame must not affect transmitted data
        run_frame('{8'h41, 1'b1, 1'b0, 0, 20, 8'h00});
        repeat (2) @(negedge clk);

        // asynchronous reset in the middle of data bit 3 (a 0 for 0xA5)
        din  = 8'hA5;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (45) @(negedge clk);
        chk("pre_rst_tx", 45, {7'b0, tx_odd}, 8'h00);
        chk("pre_rst_busy", 45, {7'b0, busy_odd}, 8'h01);
        rst = 1'b0;
        #1;
        chk("async_rst_tx_odd", 45, {7'b0, tx_odd}, 8'h01);
        chk("async_rst_tx_even", 45, {7'b0, tx_even}, 8'h01);
        chk("async_rst_busy_odd", 45, {7'b0, busy_odd}, 8'h00);
        chk("async_rst_busy_even", 45, {7'b0, busy_even}, 8'h00);
        chk("async_rst_state", 45, {5'b0, st_odd}, {5'b0, IDLE});
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("no_resume_tx", c, {7'b0, tx_odd}, 8'h01);
            chk("no_resume_busy", c, {7'b0, busy_odd}, 8'h00);
        end
        run_frame(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
